// File: rtl/wordcopy_pkg.sv
// Shared types and constants for the wordcopy job scheduler: descriptor layout,
// CSR map on both the CPU side and the accelerator side, and FSM encoding.
package wordcopy_pkg;

  typedef struct packed {
    logic [31:0] dst;
    logic [31:0] src;
    logic [31:0] num;
  } desc_t;

  localparam logic [3:0] CSR_PUSH  = 4'd0;
  localparam logic [3:0] CSR_DST   = 4'd1;
  localparam logic [3:0] CSR_SRC   = 4'd2;
  localparam logic [3:0] CSR_NUM   = 4'd3;
  localparam logic [3:0] CSR_DONE  = 4'd4;
  localparam logic [3:0] CSR_IRQEN = 4'd5;

  localparam logic [3:0] ACC_CTRL = 4'd0;
  localparam logic [3:0] ACC_DST  = 4'd1;
  localparam logic [3:0] ACC_SRC  = 4'd2;
  localparam logic [3:0] ACC_NUM  = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_WR_DST    = 3'd2,
    ST_WR_SRC    = 3'd3,
    ST_WR_NUM    = 3'd4,
    ST_WR_GO     = 3'd5,
    ST_WAIT_DONE = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  function automatic logic [31:0] pack_status(input logic [7:0] occ, input logic busy,
                                              input logic full, input logic empty);
    return {16'd0, occ, 5'd0, busy, full, empty};
  endfunction

endpackage

// File: rtl/wordcopy_scheduler_desc_fifo.sv
// Descriptor FIFO. A push against a full FIFO is dropped even if a pop happens
// in the same cycle; the slot freed by the pop is only usable on the next cycle.
module desc_fifo
  import wordcopy_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = desc_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  T                         i_wdata,
  input  logic                     i_pop,
  output T                         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_full    = (r_count == CNTW'(DEPTH));
  assign o_empty   = (r_count == CNTW'(0));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage array, no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wordcopy_scheduler.sv
// Drains queued copy descriptors in order, programming the wordcopy accelerator
// over an Avalon-MM master and counting completed jobs for the CPU.
module wordcopy_scheduler
  import wordcopy_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        acc_waitrequest,
  output logic [3:0]  acc_address,
  output logic        acc_read,
  input  logic [31:0] acc_readdata,
  output logic        acc_write,
  output logic [31:0] acc_writedata,
  output logic        irq
);

  localparam int OCW = $clog2(DEPTH) + 1;

  logic [31:0]    r_dst;
  logic [31:0]    r_src;
  logic [31:0]    r_num;
  logic [CW-1:0]  r_done_count;
  logic           r_done_pending;
  logic           r_irq_en;
  state_t         r_state;
  desc_t          r_job;
  logic           r_acc_write;
  logic           r_acc_read;
  logic [3:0]     r_acc_address;
  logic [31:0]    r_acc_writedata;

  state_t         w_state_nxt;
  desc_t          w_job_nxt;
  desc_t          w_head;
  desc_t          w_stage;
  logic           w_acc_write_nxt;
  logic           w_acc_read_nxt;
  logic [3:0]     w_acc_address_nxt;
  logic [31:0]    w_acc_writedata_nxt;
  logic           w_push_req;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [OCW-1:0] w_count;
  logic           w_busy;
  logic           w_clear;
  logic           w_unused;

  assign w_stage           = '{dst: r_dst, src: r_src, num: r_num};
  assign w_push_req        = slave_write & (slave_address == CSR_PUSH);
  assign slave_waitrequest = w_push_req & w_full;
  assign w_push            = w_push_req & ~w_full;
  assign w_pop             = (r_state == ST_POP);
  assign w_busy            = (r_state != ST_IDLE);
  assign w_clear           = slave_write & (slave_address == CSR_DONE);
  assign irq               = r_irq_en & r_done_pending;
  assign acc_write         = r_acc_write;
  assign acc_read          = r_acc_read;
  assign acc_address       = r_acc_address;
  assign acc_writedata     = r_acc_writedata;
  assign w_unused          = ^acc_readdata;

  desc_fifo #(
    .DEPTH (DEPTH),
    .T     (desc_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_stage),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next state; a job with zero words skips the accelerator entirely.
  always_comb begin
    w_state_nxt = r_state;
    w_job_nxt   = (r_state == ST_POP) ? w_head : r_job;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_POP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_POP: begin
        if (w_head.num == 32'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WR_DST;
        end
      end
      ST_WR_DST:    w_state_nxt = acc_waitrequest ? ST_WR_DST    : ST_WR_SRC;
      ST_WR_SRC:    w_state_nxt = acc_waitrequest ? ST_WR_SRC    : ST_WR_NUM;
      ST_WR_NUM:    w_state_nxt = acc_waitrequest ? ST_WR_NUM    : ST_WR_GO;
      ST_WR_GO:     w_state_nxt = acc_waitrequest ? ST_WR_GO     : ST_WAIT_DONE;
      ST_WAIT_DONE: w_state_nxt = acc_waitrequest ? ST_WAIT_DONE : ST_DONE;
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Accelerator bus is a function of the state being entered, so it can be registered.
  always_comb begin
    w_acc_write_nxt     = 1'b0;
    w_acc_read_nxt      = 1'b0;
    w_acc_address_nxt   = 4'd0;
    w_acc_writedata_nxt = 32'd0;
    case (w_state_nxt)
      ST_WR_DST: begin
        w_acc_write_nxt     = 1'b1;
        w_acc_address_nxt   = ACC_DST;
        w_acc_writedata_nxt = w_job_nxt.dst;
      end
      ST_WR_SRC: begin
        w_acc_write_nxt     = 1'b1;
        w_acc_address_nxt   = ACC_SRC;
        w_acc_writedata_nxt = w_job_nxt.src;
      end
      ST_WR_NUM: begin
        w_acc_write_nxt     = 1'b1;
        w_acc_address_nxt   = ACC_NUM;
        w_acc_writedata_nxt = w_job_nxt.num;
      end
      ST_WR_GO: begin
        w_acc_write_nxt     = 1'b1;
        w_acc_address_nxt   = ACC_CTRL;
        w_acc_writedata_nxt = 32'd1;
      end
      ST_WAIT_DONE: begin
        w_acc_read_nxt    = 1'b1;
        w_acc_address_nxt = ACC_CTRL;
      end
      default: begin
        w_acc_write_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, working descriptor and registered accelerator bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_job           <= '0;
      r_acc_write     <= 1'b0;
      r_acc_read      <= 1'b0;
      r_acc_address   <= 4'd0;
      r_acc_writedata <= 32'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_job           <= w_job_nxt;
      r_acc_write     <= w_acc_write_nxt;
      r_acc_read      <= w_acc_read_nxt;
      r_acc_address   <= w_acc_address_nxt;
      r_acc_writedata <= w_acc_writedata_nxt;
    end
  end

  // CPU-writable staging and interrupt-enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst    <= 32'd0;
      r_src    <= 32'd0;
      r_num    <= 32'd0;
      r_irq_en <= 1'b0;
    end else if (slave_write) begin
      case (slave_address)
        CSR_DST:   r_dst    <= slave_writedata;
        CSR_SRC:   r_src    <= slave_writedata;
        CSR_NUM:   r_num    <= slave_writedata;
        CSR_IRQEN: r_irq_en <= slave_writedata[0];
        default:   r_irq_en <= r_irq_en;
      endcase
    end else begin
      r_irq_en <= r_irq_en;
    end
  end

  // Completion counter; a clear landing in the DONE cycle still records that job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_count   <= '0;
      r_done_pending <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_done_count   <= w_clear ? CW'(1) : r_done_count + CW'(1);
      r_done_pending <= 1'b1;
    end else if (w_clear) begin
      r_done_count   <= '0;
      r_done_pending <= 1'b0;
    end else begin
      r_done_pending <= r_done_pending;
    end
  end

  // CSR read mux over registered state.
  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        CSR_PUSH:  slave_readdata = pack_status(8'(w_count), w_busy, w_full, w_empty);
        CSR_DST:   slave_readdata = r_dst;
        CSR_SRC:   slave_readdata = r_src;
        CSR_NUM:   slave_readdata = r_num;
        CSR_DONE:  slave_readdata = 32'(r_done_count);
        CSR_IRQEN: slave_readdata = {31'd0, r_irq_en};
        default:   slave_readdata = 32'd0;
      endcase
    end else begin
      slave_readdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_wordcopy_scheduler.sv
// Self-checking bench: directed timing scenarios plus randomized jobs scored
// against an expected accelerator transaction queue built from each descriptor.
module tb_wordcopy_scheduler;
  import wordcopy_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        acc_waitrequest;
  logic [3:0]  acc_address;
  logic        acc_read;
  logic [31:0] acc_readdata;
  logic        acc_write;
  logic [31:0] acc_writedata;
  logic        irq;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_jobs   = 0;
  bit          rand_wait = 1'b0;
  logic [36:0] exp_q [$];
  logic [37:0] exp_lat [8];
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  wordcopy_scheduler #(.DEPTH(4), .CW(8)) dut (
    .clk (clk), .rst (rst),
    .slave_waitrequest (slave_waitrequest), .slave_address (slave_address),
    .slave_read (slave_read), .slave_readdata (slave_readdata),
    .slave_write (slave_write), .slave_writedata (slave_writedata),
    .acc_waitrequest (acc_waitrequest), .acc_address (acc_address),
    .acc_read (acc_read), .acc_readdata (acc_readdata),
    .acc_write (acc_write), .acc_writedata (acc_writedata),
    .irq (irq)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [37:0] bus_view();
    return {acc_read, acc_write, (acc_read | acc_write) ? acc_address : 4'd0,
            acc_write ? acc_writedata : 32'd0};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    acc_readdata = $urandom;
    if (rand_wait) acc_waitrequest = ($urandom_range(0, 2) == 0);
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    int n;
    n = 0;
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    while (slave_waitrequest && n < 300) begin
      tick(); @(negedge clk); n++;
    end
    if (n >= 300) check_eq("wr_accept_timeout", 64'(n), 64'd0);
    tick();
    slave_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    d = slave_readdata;
    tick();
    slave_read = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr_rd(a, v);
    check_eq(tag, 64'(v), 64'(exp));
  endtask

  // Reference: a job with num words produces four writes and a read barrier, in push order.
  task automatic model_add(input logic [31:0] d, input logic [31:0] s, input logic [31:0] n);
    n_jobs++;
    if (n != 32'd0) begin
      exp_q.push_back({1'b0, 4'd1, d});
      exp_q.push_back({1'b0, 4'd2, s});
      exp_q.push_back({1'b0, 4'd3, n});
      exp_q.push_back({1'b0, 4'd0, 32'd1});
      exp_q.push_back({1'b1, 4'd0, 32'd0});
    end
  endtask

  task automatic stage(input logic [31:0] d, input logic [31:0] s, input logic [31:0] n);
    csr_wr(CSR_DST, d); csr_wr(CSR_SRC, s); csr_wr(CSR_NUM, n);
  endtask

  task automatic push_job(input logic [31:0] d, input logic [31:0] s, input logic [31:0] n);
    stage(d, s, n);
    csr_wr(CSR_PUSH, 32'd0);
    model_add(d, s, n);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int n;
    n = 0;
    do begin csr_rd(CSR_PUSH, s); n++; end while (s != 32'h1 && n < 3000);
    check_eq("drain_status", 64'(s), 64'h1);
    check_eq("drain_queue_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Accelerator-side scoreboard: every accepted transfer must be the next expected one.
  initial forever begin
    logic [36:0] t;
    @(negedge clk);
    if (!rst && (acc_write || acc_read)) begin
      check_eq("acc_rd_wr_exclusive", 64'(acc_write & acc_read), 64'd0);
      if (!acc_waitrequest) begin
        if (exp_q.size() == 0) begin
          check_eq("acc_unexpected_txn", 64'(exp_q.size()), 64'd1);
        end else begin
          t = exp_q.pop_front();
          check_eq("acc_txn", 64'({acc_read, acc_address, acc_read ? 32'd0 : acc_writedata}),
                   64'(t));
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_lat[0] = '0;
    exp_lat[1] = '0;
    exp_lat[2] = {1'b0, 1'b1, 4'd1, 32'h40};
    exp_lat[3] = {1'b0, 1'b1, 4'd2, 32'h0};
    exp_lat[4] = {1'b0, 1'b1, 4'd3, 32'h4};
    exp_lat[5] = {1'b0, 1'b1, 4'd0, 32'h1};
    exp_lat[6] = {1'b1, 1'b0, 4'd0, 32'h0};
    exp_lat[7] = '0;
    rst = 1'b1; slave_address = 4'd0; slave_read = 1'b0; slave_write = 1'b0;
    slave_writedata = 32'd0; acc_waitrequest = 1'b0; acc_readdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", 64'({acc_read, acc_write, irq, slave_waitrequest, acc_address,
                                  acc_writedata}), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    rd_check("reset_status", CSR_PUSH, 32'h1);
    rd_check("reset_done", CSR_DONE, 32'h0);
    rd_check("reset_irqen", CSR_IRQEN, 32'h0);
    csr_wr(4'd9, 32'hFFFF_FFFF);
    rd_check("unmapped_read", 4'd9, 32'h0);

    // Single job latency and exact bus sequence.
    stage(32'h40, 32'h0, 32'd4);
    csr_wr(CSR_PUSH, 32'd0);
    model_add(32'h40, 32'h0, 32'd4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("latency_cyc%0d", k), 64'(bus_view()), 64'(exp_lat[k]));
    end
    tick();
    rd_check("job1_done_count", CSR_DONE, 32'd1);
    check_eq("job1_irq_disabled", 64'(irq), 64'd0);
    rd_check("staging_retained", CSR_DST, 32'h40);

    // Long completion stall with interrupts enabled.
    csr_wr(CSR_DONE, 32'd0);
    csr_wr(CSR_IRQEN, 32'hFFFF_FFFF);
    rd_check("irqen_bit0_only", CSR_IRQEN, 32'h1);
    push_job(32'h100, 32'h200, 32'd3);
    for (int k = 0; k < 6; k++) @(negedge clk);
    @(posedge clk); #1; acc_waitrequest = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("hold_read_%0d", k), 64'({acc_read, irq}), 64'b10);
    end
    @(posedge clk); #1; acc_waitrequest = 1'b0;
    @(negedge clk); check_eq("release_cycle", 64'({acc_read, irq}), 64'b10);
    @(negedge clk); check_eq("done_cycle_irq", 64'({acc_read, irq}), 64'b00);
    @(negedge clk); check_eq("irq_raised", 64'({acc_read, irq}), 64'b01);
    tick();
    csr_wr(CSR_DONE, 32'h1234);
    check_eq("irq_cleared", 64'(irq), 64'd0);
    rd_check("count_cleared", CSR_DONE, 32'd0);

    // Fill the FIFO behind a stalled job, then push against a full FIFO.
    acc_waitrequest = 1'b1;
    push_job(32'hA0, 32'hA1, 32'd2);
    push_job(32'hB0, 32'hB1, 32'd2);
    push_job(32'hC0, 32'hC1, 32'd2);
    push_job(32'hD0, 32'hD1, 32'd2);
    push_job(32'hE0, 32'hE1, 32'd2);
    rd_check("full_status", CSR_PUSH, 32'h0000_0406);
    stage(32'hF0, 32'hF1, 32'd2);
    slave_address = CSR_PUSH; slave_writedata = 32'd0; slave_write = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("full_stall_%0d", k), 64'(slave_waitrequest), 64'd1);
      @(posedge clk); #1;
    end
    acc_waitrequest = 1'b0;
    csr_wr(CSR_PUSH, 32'd0);
    model_add(32'hF0, 32'hF1, 32'd2);
    wait_idle();
    rd_check("six_jobs_done", CSR_DONE, 32'd6);

    // Zero-length job between two real ones.
    csr_wr(CSR_DONE, 32'd0);
    push_job(32'h1000, 32'h2000, 32'd8);
    push_job(32'h3000, 32'h4000, 32'd0);
    push_job(32'h5000, 32'h6000, 32'd8);
    wait_idle();
    rd_check("zero_len_done", CSR_DONE, 32'd3);

    // Reset while programming SRC, with another job queued.
    push_job(32'h77, 32'h88, 32'd5);
    for (int k = 0; k < 3; k++) @(negedge clk);
    @(posedge clk); #1; acc_waitrequest = 1'b1;
    @(negedge clk);
    check_eq("in_wr_src", 64'(bus_view()), 64'({1'b0, 1'b1, 4'd2, 32'h88}));
    tick();
    push_job(32'h99, 32'hAA, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("reset_drops_acc", 64'({acc_read, acc_write}), 64'd0);
    slave_address = CSR_PUSH; slave_read = 1'b1; #1;
    check_eq("reset_status_mid", 64'(slave_readdata), 64'h1);
    slave_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; acc_waitrequest = 1'b0;
    exp_q.delete();
    rd_check("post_rst_dst", CSR_DST, 32'd0);
    rd_check("post_rst_src", CSR_SRC, 32'd0);
    rd_check("post_rst_num", CSR_NUM, 32'd0);
    rd_check("post_rst_status", CSR_PUSH, 32'h1);

    // Clear landing in the DONE cycle.
    push_job(32'h11, 32'h22, 32'd1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 6) check_eq("anchor_wait_done", 64'(acc_read), 64'd1);
      @(posedge clk); #1;
    end
    csr_wr(CSR_DONE, 32'hDEAD);
    rd_check("clear_vs_done_count", CSR_DONE, 32'd1);
    csr_wr(CSR_IRQEN, 32'd1);
    check_eq("clear_vs_done_pending", 64'(irq), 64'd1);

    // Randomized jobs with random accelerator stalls.
    begin
      logic [31:0] d, s, n;
      int jobs;
      bit en;
      csr_wr(CSR_DONE, 32'd0);
      en = $urandom_range(0, 1);
      csr_wr(CSR_IRQEN, 32'(en));
      rand_wait = 1'b1;
      jobs = 0;
      for (int j = 0; j < 24; j++) begin
        d = $urandom; s = $urandom;
        n = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 64));
        stage(d, s, n);
        if ((j % 6) == 0) rd_check("rand_stage_src", CSR_SRC, s);
        csr_wr(CSR_PUSH, 32'd0);
        model_add(d, s, n);
        jobs++;
      end
      wait_idle();
      rand_wait = 1'b0;
      acc_waitrequest = 1'b0;
      rd_check("rand_done_count", CSR_DONE, 32'(jobs % 256));
      check_eq("rand_irq", 64'(irq), 64'(en));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
